// File: rtl/display_scan_controller_pkg.sv
// Shared definitions for the multiplexed 7-segment scan controller:
// scan state encoding, all-off segment pattern and a width helper.
package display_scan_controller_pkg;

    // Per-slot scan phase: dead-time first, then the digit is lit.
    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } scan_state_t;

    // Bits needed to hold 0..value-1 (never less than 1).
    function automatic int clog2(input int value);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // Segment bus value that leaves every segment and the dp dark.
    function automatic logic [7:0] seg_off(input bit common_anode);
        return common_anode ? 8'hFF : 8'h00;
    endfunction

endpackage

// File: rtl/bcd2segments.sv
// Combinational BCD to 7-segment decoder. Output order is {a,b,c,d,e,f,g,dp};
// the dp position is always driven dark. Codes above 9 decode to blank.
module bcd2segments #(
    parameter int COMMON_ANODE = 1
) (
    input  logic [3:0] bcd,
    output logic [7:0] segments
);

    logic [6:0] lit;

    // Active-high glyph table {a,b,c,d,e,f,g}
    always_comb begin
        lit = 7'b0000000;
        case (bcd)
            4'd0:    lit = 7'b1111110;
            4'd1:    lit = 7'b0110000;
            4'd2:    lit = 7'b1101101;
            4'd3:    lit = 7'b1111001;
            4'd4:    lit = 7'b0110011;
            4'd5:    lit = 7'b1011011;
            4'd6:    lit = 7'b1011111;
            4'd7:    lit = 7'b1110000;
            4'd8:    lit = 7'b1111111;
            4'd9:    lit = 7'b1111011;
            default: lit = 7'b0000000;
        endcase
    end

    assign segments = (COMMON_ANODE != 0) ? ~{lit, 1'b0} : {lit, 1'b0};

endmodule

// File: rtl/display_scan_controller.sv
// Time-multiplexed scan controller for an N-digit 7-segment display.
// A shadow buffer takes loads at any time; the displayed (active) word only
// changes on the frame wrap so a frame never mixes old and new digits.
module display_scan_controller
    import display_scan_controller_pkg::*;
#(
    parameter int COMMON_ANODE     = 1,
    parameter int DIGIT_ACTIVE_LOW = 1,
    parameter int NUM_DIGITS       = 4,
    parameter int SCAN_DIV         = 50000,
    parameter int BLANK_CYCLES     = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [4*NUM_DIGITS-1:0]   value_in,
    input  logic [NUM_DIGITS-1:0]     dp_in,
    input  logic                      load,
    input  logic                      lz_blank,
    output logic [7:0]                segments,
    output logic [NUM_DIGITS-1:0]     digit_en,
    output logic                      frame_done
);

    localparam int CW = clog2(SCAN_DIV);
    localparam int IW = clog2(NUM_DIGITS);
    localparam logic [7:0] SEG_OFF = seg_off(COMMON_ANODE != 0);
    // XOR mask that turns an active-high one-hot into pin polarity.
    localparam logic [NUM_DIGITS-1:0] EN_OFF = {NUM_DIGITS{DIGIT_ACTIVE_LOW != 0}};

    logic [4*NUM_DIGITS-1:0] shadow_val_reg, active_val_reg;
    logic [NUM_DIGITS-1:0]   shadow_dp_reg, active_dp_reg;
    logic                    pending_reg;
    logic [CW-1:0]           cnt_reg, cnt_next;
    logic [IW-1:0]           idx_reg, idx_next;
    scan_state_t             state_reg, state_next;
    logic [7:0]              segments_reg;
    logic [NUM_DIGITS-1:0]   digit_en_reg;
    logic                    frame_done_reg;

    logic                    slot_end, last_digit, wrap;
    logic [3:0]              digit_nib [NUM_DIGITS];
    logic [NUM_DIGITS-1:0]   digit_zero, lz_mask;
    logic [3:0]              cur_nib;
    logic [7:0]              dec_seg, show_seg;
    logic                    dp_pin;
    logic [NUM_DIGITS-1:0]   en_show;

    assign slot_end   = (cnt_reg == CW'(SCAN_DIV - 1));
    assign last_digit = (idx_reg == IW'(NUM_DIGITS - 1));
    assign wrap       = slot_end && last_digit;

    assign cnt_next   = slot_end ? '0 : cnt_reg + 1'b1;
    assign state_next = (cnt_next < CW'(BLANK_CYCLES)) ? ST_BLANK : ST_SHOW;
    assign idx_next   = slot_end ? (last_digit ? '0 : idx_reg + 1'b1) : idx_reg;

    // Split the active word into digits; a digit is a leading zero when it
    // and every more-significant digit are zero. Digit 0 always shows.
    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            assign digit_nib[gi]  = active_val_reg[4*gi +: 4];
            assign digit_zero[gi] = (digit_nib[gi] == 4'd0);
            if (gi == 0) begin : g_lsd
                assign lz_mask[gi] = 1'b0;
            end else begin : g_upper
                assign lz_mask[gi] = lz_blank & (&digit_zero[NUM_DIGITS-1:gi]);
            end
        end
    endgenerate

    assign cur_nib = digit_nib[idx_reg];

    bcd2segments #(
        .COMMON_ANODE (COMMON_ANODE)
    ) u_bcd2segments (
        .bcd      (cur_nib),
        .segments (dec_seg)
    );

    // Pattern for the current digit: decoder a-g unless leading-zero
    // blanked, dp taken from the active buffer instead of the decoder.
    always_comb begin
        dp_pin   = (COMMON_ANODE != 0) ? ~active_dp_reg[idx_reg] : active_dp_reg[idx_reg];
        show_seg = {(lz_mask[idx_reg] ? SEG_OFF[7:1] : dec_seg[7:1]), dp_pin};
        en_show  = NUM_DIGITS'(1) << idx_reg;
    end

    // Scan FSM: slot counter, digit index and registered pin drivers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg        <= '0;
            idx_reg        <= '0;
            state_reg      <= ST_BLANK;
            segments_reg   <= SEG_OFF;
            digit_en_reg   <= EN_OFF;
            frame_done_reg <= 1'b0;
        end else begin
            cnt_reg        <= cnt_next;
            idx_reg        <= idx_next;
            state_reg      <= state_next;
            frame_done_reg <= wrap;
            if (state_reg == ST_SHOW) begin
                segments_reg <= show_seg;
                digit_en_reg <= en_show ^ EN_OFF;
            end else begin
                segments_reg <= SEG_OFF;
                digit_en_reg <= EN_OFF;
            end
        end
    end

    // Double buffer: loads land in the shadow, which is promoted at the wrap.
    // A load on the wrap cycle itself bypasses the shadow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_val_reg <= '0;
            shadow_dp_reg  <= '0;
            active_val_reg <= '0;
            active_dp_reg  <= '0;
            pending_reg    <= 1'b0;
        end else if (wrap) begin
            if (load) begin
                active_val_reg <= value_in;
                active_dp_reg  <= dp_in;
                shadow_val_reg <= value_in;
                shadow_dp_reg  <= dp_in;
            end else if (pending_reg) begin
                active_val_reg <= shadow_val_reg;
                active_dp_reg  <= shadow_dp_reg;
            end
            pending_reg <= 1'b0;
        end else if (load) begin
            shadow_val_reg <= value_in;
            shadow_dp_reg  <= dp_in;
            pending_reg    <= 1'b1;
        end
    end

    assign segments   = segments_reg;
    assign digit_en   = digit_en_reg;
    assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_display_scan_controller.sv
// Self-checking bench for display_scan_controller (4 digits, 4-cycle slots,
// 1 blank cycle, common anode, active-low digit enables).
module tb_display_scan_controller;

    localparam int ND    = 4;
    localparam int SD    = 4;
    localparam int BC    = 1;
    localparam int FRAME = ND * SD;

    // Lit segments {a..g} for digits 0..9, active-high.
    localparam logic [6:0] GLYPH [10] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
        7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011
    };

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] value_in = '0;
    logic [3:0]  dp_in = '0;
    logic        load = 1'b0;
    logic        lz_blank = 1'b0;
    logic [7:0]  segments;
    logic [3:0]  digit_en;
    logic        frame_done;

    int total = 0;
    int bad = 0;

    // Reference model state: position of the current cycle within the scan
    // and the contents of the display buffers.
    int          m_g;
    logic [15:0] m_active, m_shadow;
    logic [3:0]  m_adp, m_sdp;
    logic        m_pend;

    typedef struct {
        logic [15:0] val;
        logic [3:0]  dp;
        logic        lz;
        logic [31:0] exp_segs; // {digit3, digit2, digit1, digit0}
    } vec_t;

    vec_t vecs [6];

    display_scan_controller #(
        .COMMON_ANODE     (1),
        .DIGIT_ACTIVE_LOW (1),
        .NUM_DIGITS       (ND),
        .SCAN_DIV         (SD),
        .BLANK_CYCLES     (BC)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .value_in   (value_in),
        .dp_in      (dp_in),
        .load       (load),
        .lz_blank   (lz_blank),
        .segments   (segments),
        .digit_en   (digit_en),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, expv);
        end
    endtask

    // Pins that follow a cycle spent at scan position g, derived from the
    // slot/offset arithmetic of the scan and the buffered word.
    function automatic void model_pins(input int g, input logic [15:0] av, input logic [3:0] adp,
                                       input logic lz, output logic [7:0] s,
                                       output logic [3:0] en, output logic fd);
        int slot;
        int off;
        int nib;
        logic blank;
        logic [6:0] ag;
        slot = (g / SD) % ND;
        off  = g % SD;
        fd   = ((g % FRAME) == FRAME - 1);
        if (off < BC) begin
            s  = 8'hFF;
            en = 4'hF;
        end else begin
            en    = ~(4'(1) << slot);
            nib   = int'((av >> (4 * slot)) & 16'hF);
            blank = lz && (slot != 0) && ((av >> (4 * slot)) == 16'h0);
            ag    = (blank || nib > 9) ? 7'b0 : GLYPH[nib];
            s     = ~{ag, adp[slot]};
        end
    endfunction

    // One clock: drive inputs, predict the pins, advance the model, compare.
    task automatic step(input logic ld, input logic [15:0] v, input logic [3:0] d, input logic l);
        logic [7:0] e_seg;
        logic [3:0] e_en;
        logic       e_fd;
        load = ld; value_in = v; dp_in = d; lz_blank = l;
        model_pins(m_g, m_active, m_adp, l, e_seg, e_en, e_fd);
        if (ld && (m_g % FRAME == FRAME - 1)) begin
            m_active = v; m_adp = d; m_pend = 1'b0;
        end else if (ld) begin
            m_shadow = v; m_sdp = d; m_pend = 1'b1;
        end else if ((m_g % FRAME == FRAME - 1) && m_pend) begin
            m_active = m_shadow; m_adp = m_sdp; m_pend = 1'b0;
        end
        m_g++;
        @(posedge clk);
        @(negedge clk);
        load = 1'b0;
        chk("pins", {19'd0, e_fd, e_en, e_seg}, {19'd0, frame_done, digit_en, segments});
    endtask

    task automatic model_reset();
        m_g = 0; m_active = '0; m_shadow = '0; m_adp = '0; m_sdp = '0; m_pend = 1'b0;
    endtask

    // Assert reset at a negedge, check the pins go dark immediately, release.
    task automatic apply_reset(input string name);
        rst_n = 1'b0;
        load = 1'b0;
        model_reset();
        #1;
        chk({name, "_async"}, {19'd0, frame_done, digit_en, segments}, {19'd0, 1'b0, 4'hF, 8'hFF});
        @(negedge clk);
        @(negedge clk);
        chk({name, "_held"}, {19'd0, frame_done, digit_en, segments}, {19'd0, 1'b0, 4'hF, 8'hFF});
        rst_n = 1'b1;
    endtask

    initial begin
        logic [7:0]  got [4];
        logic        seen;
        logic [15:0] rv;
        logic        rlz;

        vecs[0] = '{16'h1234, 4'b0000, 1'b0, {8'h9F, 8'h25, 8'h0D, 8'h99}};
        vecs[1] = '{16'h0050, 4'b1000, 1'b1, {8'hFE, 8'hFF, 8'h49, 8'h03}};
        vecs[2] = '{16'h0050, 4'b1000, 1'b0, {8'h02, 8'h03, 8'h49, 8'h03}};
        vecs[3] = '{16'h00A0, 4'b0000, 1'b0, {8'h03, 8'h03, 8'hFF, 8'h03}};
        vecs[4] = '{16'h8765, 4'b0101, 1'b1, {8'h01, 8'h1E, 8'h41, 8'h48}};
        vecs[5] = '{16'h0A00, 4'b0000, 1'b1, {8'hFF, 8'hFF, 8'h03, 8'h03}};

        // Power-on reset, then the initial scan of an all-zero word.
        @(negedge clk);
        apply_reset("reset");
        $display("reset released at %0t", $time);
        for (int i = 0; i < 2 * FRAME; i++) step(1'b0, 16'h0, 4'h0, 1'b0);

        // Table vectors: load mid-frame, wait for the wrap, capture one frame.
        for (int vi = 0; vi < 6; vi++) begin
            if (m_g % FRAME == FRAME - 1) step(1'b0, 16'h0, 4'h0, vecs[vi].lz);
            step(1'b1, vecs[vi].val, vecs[vi].dp, vecs[vi].lz);
            seen = 1'b0;
            for (int c = 0; c < 2 * FRAME && !seen; c++) begin
                step(1'b0, 16'h0, 4'h0, vecs[vi].lz);
                seen = frame_done;
            end
            chk("frame_done_seen", {31'd0, seen}, 32'd1);
            for (int d = 0; d < 4; d++) got[d] = 8'h00;
            for (int c = 0; c < FRAME; c++) begin
                step(1'b0, 16'h0, 4'h0, vecs[vi].lz);
                for (int d = 0; d < 4; d++) begin
                    if (digit_en == ~(4'(1) << d)) got[d] = segments;
                end
            end
            for (int d = 0; d < 4; d++) begin
                chk($sformatf("vec%0d_digit%0d", vi, d), {24'd0, got[d]},
                    {24'd0, vecs[vi].exp_segs[8*d +: 8]});
            end
            $display("vector %0d value=%h dp=%b lz=%b checked", vi, vecs[vi].val, vecs[vi].dp, vecs[vi].lz);
        end

        // Load landing exactly on the wrap cycle goes straight to the display.
        for (int c = 0; c < FRAME && (m_g % FRAME != FRAME - 1); c++) step(1'b0, 16'h0, 4'h0, 1'b0);
        step(1'b1, 16'h0009, 4'h0, 1'b0);
        step(1'b0, 16'h0, 4'h0, 1'b0);
        step(1'b0, 16'h0, 4'h0, 1'b0);
        chk("wrap_load_digit0", {20'd0, digit_en, segments}, {20'd0, 4'hE, 8'h09});
        $display("wrap-cycle load checked");
        for (int c = 0; c < FRAME; c++) step(1'b0, 16'h0, 4'h0, 1'b0);

        // Reset during digit 2 with a load still pending: nothing survives.
        for (int c = 0; c < FRAME && (m_g % FRAME != 0); c++) step(1'b0, 16'h0, 4'h0, 1'b0);
        step(1'b1, 16'h4321, 4'hF, 1'b0);
        seen = 1'b0;
        for (int c = 0; c < 2 * FRAME && !seen; c++) begin
            step(1'b0, 16'h0, 4'h0, 1'b0);
            seen = (digit_en == 4'hB);
        end
        chk("digit2_reached", {31'd0, seen}, 32'd1);
        apply_reset("midreset");
        for (int c = 0; c < 2 * FRAME + 2; c++) step(1'b0, 16'h0, 4'h0, 1'b0);
        $display("mid-scan reset checked");

        // Randomised traffic against the reference model.
        rlz = 1'b0;
        for (int c = 0; c < 600; c++) begin
            for (int d = 0; d < 4; d++) rv[4*d +: 4] = 4'($urandom_range(0, 11));
            if ($urandom_range(0, 3) == 0) rv[15:8] = 8'h00;
            if ($urandom_range(0, 15) == 0) rlz = ~rlz;
            step(($urandom_range(0, 7) == 0), rv, 4'($urandom_range(0, 15)), rlz);
        end
        $display("random traffic done");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
